// File: rtl/eth_tx_scheduler.sv
// Frame-level round-robin scheduler feeding the Ethernet TX packer from two dibit requesters.
// One requester owns each whole frame; an empty arbitration produces a pad frame.
module eth_tx_scheduler #(
  parameter int         DATA_DIBITS = 1280,
  parameter logic [1:0] PAD_DIBIT   = 2'b00,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       src_valid,
  input  logic [3:0]       src_data,
  output logic [1:0]       src_ready,
  output logic [1:0]       grant,
  output logic [1:0]       frame_done,
  output logic             frame_err,
  input  logic             stall,
  output logic             axiiv,
  output logic [1:0]       axiid,
  output logic             cancelled,
  output logic [CNT_W-1:0] underrun_count,
  output logic [CNT_W-1:0] pad_frames
);

  // state  | meaning
  // IDLE   | waiting for the packer to drop stall; that cycle arbitrates and pops dibit 0
  // STREAM | forwarding granted requester dibits (or pad dibits) once per stall-low cycle
  // DRAIN  | frame finished or aborted; wait for stall so the last data cycle starts nothing
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  localparam logic [12:0] LAST_CNT = 13'(DATA_DIBITS);

  state_t      state, state_nxt;
  logic [12:0] cnt, cnt_base;
  logic        last;
  logic [1:0]  arb, g_cur, pop_dibit;
  logic        deciding, pop_ok, pop, underrun, early, done;

  always_comb begin
    state_nxt  = state;
    arb        = 2'b00;
    src_ready  = 2'b00;
    frame_done = 2'b00;
    pop        = 1'b0;
    underrun   = 1'b0;
    pop_dibit  = PAD_DIBIT;

    case (req)
      2'b11:   arb = last ? 2'b01 : 2'b10;
      2'b01:   arb = 2'b01;
      2'b10:   arb = 2'b10;
      default: arb = 2'b00;
    endcase

    // rst gates the combinational strobes so a held reset never pops a source
    deciding = rst && (state == IDLE) && !stall;
    early    = rst && (state == STREAM) && stall;
    g_cur    = deciding ? arb : grant;
    cnt_base = deciding ? 13'd0 : cnt;
    pop_ok   = (deciding || (rst && (state == STREAM) && !stall)) && (cnt_base < LAST_CNT);

    if (pop_ok) begin
      if (g_cur == 2'b00) begin
        pop = 1'b1;
      end else if ((src_valid & g_cur) != 2'b00) begin
        pop       = 1'b1;
        src_ready = g_cur;
        pop_dibit = g_cur[1] ? src_data[3:2] : src_data[1:0];
      end else begin
        underrun = 1'b1;
      end
    end

    done       = pop && ((cnt_base + 13'd1) == LAST_CNT);
    frame_done = done ? g_cur : 2'b00;

    case (state)
      IDLE:    if (deciding) state_nxt = (underrun || done) ? DRAIN : STREAM;
      STREAM: begin
        if (early)                 state_nxt = IDLE;
        else if (underrun || done) state_nxt = DRAIN;
      end
      DRAIN:   if (stall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      grant          <= 2'b00;
      cnt            <= 13'd0;
      last           <= 1'b1;
      axiiv          <= 1'b0;
      axiid          <= 2'b00;
      cancelled      <= 1'b0;
      frame_err      <= 1'b0;
      underrun_count <= '0;
      pad_frames     <= '0;
    end else begin
      state     <= state_nxt;
      grant     <= (state_nxt == STREAM) ? g_cur : 2'b00;
      cnt       <= pop ? cnt_base + 13'd1 : cnt_base;
      axiiv     <= pop;
      if (pop) axiid <= pop_dibit;
      cancelled <= underrun;
      frame_err <= underrun | early;
      if (underrun || (done && (g_cur != 2'b00))) last <= g_cur[1];
      if ((underrun || early) && (underrun_count != '1)) underrun_count <= underrun_count + 1'b1;
      if (done && (g_cur == 2'b00) && (pad_frames != '1)) pad_frames <= pad_frames + 1'b1;
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: packer stall model, source model and a dibit scoreboard.
module tb_eth_tx_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [1:0] src_valid = 2'b00;
  logic [3:0] src_data = 4'h0;
  logic       stall = 1'b1;
  logic [1:0] src_ready, grant, frame_done, axiid;
  logic       frame_err, axiiv, cancelled;
  logic [7:0] underrun_count, pad_frames;

  int checks = 0;
  int failures = 0;
  int exp_under = 0;
  int exp_pad = 0;
  logic [1:0] exp_q[$];

  eth_tx_scheduler dut (
    .clk(clk), .rst(rst), .req(req), .src_valid(src_valid), .src_data(src_data),
    .src_ready(src_ready), .grant(grant), .frame_done(frame_done), .frame_err(frame_err),
    .stall(stall), .axiiv(axiiv), .axiid(axiid), .cancelled(cancelled),
    .underrun_count(underrun_count), .pad_frames(pad_frames)
  );

  always #5 clk = ~clk;

  // Packer stall-low window is 1281 cycles: one lead cycle plus 1280 data cycles.
  task automatic drive_frame(input string nm, input logic [1:0] rq, input logic [1:0] g,
                             input int under_at, input int stall_at, input int rst_at);
    bit         active;
    int         pops;
    logic       e_cancel, e_err;
    logic [1:0] e_grant, e_sr, e_fd, w;
    active = 1'b1; pops = 0; e_cancel = 1'b0; e_err = 1'b0; e_grant = 2'b00;
    req = rq;
    for (int i = 0; i <= 1282; i++) begin
      @(negedge clk);
      checks++;
      if (axiiv !== (exp_q.size() != 0)) begin
        failures++;
        if (failures <= 30) $display("FAIL %s axiiv cyc=%0d got=%b want=%b", nm, i, axiiv, exp_q.size() != 0);
      end
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        if (axiiv === 1'b1) begin
          checks++;
          if (axiid !== w) begin
            failures++;
            if (failures <= 30) $display("FAIL %s axiid cyc=%0d got=%b want=%b", nm, i, axiid, w);
          end
        end
      end
      checks++;
      if (cancelled !== e_cancel) begin
        failures++;
        if (failures <= 30) $display("FAIL %s cancelled cyc=%0d got=%b want=%b", nm, i, cancelled, e_cancel);
      end
      checks++;
      if (frame_err !== e_err) begin
        failures++;
        if (failures <= 30) $display("FAIL %s frame_err cyc=%0d got=%b want=%b", nm, i, frame_err, e_err);
      end
      checks++;
      if (grant !== e_grant) begin
        failures++;
        if (failures <= 30) $display("FAIL %s grant cyc=%0d got=%b want=%b", nm, i, grant, e_grant);
      end
      if (i == 1282) break;

      rst       = (i == rst_at) ? 1'b0 : 1'b1;
      stall     = (i >= 1281) || (stall_at >= 0 && i >= stall_at) || (rst_at >= 0 && i > rst_at);
      src_valid = (i == under_at) ? (2'b11 & ~g) : 2'b11;
      src_data  = 4'($urandom_range(0, 15));
      #1;
      e_sr = 2'b00; e_fd = 2'b00; e_cancel = 1'b0; e_err = 1'b0;
      if (!rst) begin
        active = 1'b0; exp_under = 0; exp_pad = 0;
      end else if (active && stall) begin
        active = 1'b0; e_err = 1'b1; exp_under++;
      end else if (active && pops < 1280) begin
        if (g == 2'b00) begin
          exp_q.push_back(2'b00); pops++;
        end else if ((src_valid & g) != 2'b00) begin
          e_sr = g;
          exp_q.push_back(g[1] ? src_data[3:2] : src_data[1:0]);
          pops++;
        end else begin
          active = 1'b0; e_cancel = 1'b1; e_err = 1'b1; exp_under++;
        end
        if (pops == 1280) begin
          if (g != 2'b00) e_fd = g; else exp_pad++;
          active = 1'b0;
        end
      end
      checks++;
      if (src_ready !== e_sr) begin
        failures++;
        if (failures <= 30) $display("FAIL %s src_ready cyc=%0d got=%b want=%b", nm, i, src_ready, e_sr);
      end
      checks++;
      if (frame_done !== e_fd) begin
        failures++;
        if (failures <= 30) $display("FAIL %s frame_done cyc=%0d got=%b want=%b", nm, i, frame_done, e_fd);
      end
      e_grant = active ? g : 2'b00;
    end
    checks++;
    if (underrun_count !== 8'(exp_under)) begin
      failures++;
      $display("FAIL %s underrun_count got=%0d want=%0d", nm, underrun_count, exp_under);
    end
    checks++;
    if (pad_frames !== 8'(exp_pad)) begin
      failures++;
      $display("FAIL %s pad_frames got=%0d want=%0d", nm, pad_frames, exp_pad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; stall = 1'b0; req = 2'b01; src_valid = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({grant, src_ready, frame_done, frame_err, cancelled, axiiv, axiid} !== 11'b0) begin
      failures++;
      $display("FAIL reset outputs got=%b want=0", {grant, src_ready, frame_done, frame_err, cancelled, axiiv, axiid});
    end
    checks++;
    if ({underrun_count, pad_frames} !== 16'h0) begin
      failures++;
      $display("FAIL reset counters got=%h want=0", {underrun_count, pad_frames});
    end
    stall = 1'b1; rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    drive_frame("rr0", 2'b11, 2'b01, -1, -1, -1);
    drive_frame("rr1", 2'b11, 2'b10, -1, -1, -1);
    drive_frame("rr2", 2'b11, 2'b01, -1, -1, -1);
    drive_frame("rr3", 2'b11, 2'b10, -1, -1, -1);
  endtask

  task automatic test_pad();
    drive_frame("pad", 2'b00, 2'b00, -1, -1, -1);
  endtask

  task automatic test_underrun();
    drive_frame("underrun", 2'b01, 2'b01, 500, -1, -1);
    drive_frame("after_underrun", 2'b11, 2'b10, -1, -1, -1);
  endtask

  task automatic test_single();
    drive_frame("single", 2'b01, 2'b01, -1, -1, -1);
  endtask

  task automatic test_early_stall();
    drive_frame("early_stall", 2'b01, 2'b01, -1, 100, -1);
  endtask

  task automatic test_reset_mid_stream();
    // pointer now favours requester 1, so only a real reset lets requester 0 win the next tie
    drive_frame("rst_mid", 2'b11, 2'b10, -1, -1, 700);
    drive_frame("after_rst", 2'b11, 2'b01, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_pad();
    test_underrun();
    test_single();
    test_early_stall();
    test_reset_mid_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
